// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory port arbiter: default bus widths,
// the arbiter FSM state encoding and the fill value returned by aborted reads.
package cpu_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  // A read that times out returns this bit replicated across the data word.
  localparam logic TIMEOUT_FILL_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Saturating wait-cycle counter for the memory arbiter. The counter is forced
// to zero by clr and advances by one on inc until it reaches MAX, where the
// expired flag is raised and the value holds.
module arb_timeout_cnt #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_r;

  // Count wait cycles; a clear wins over an increment, saturate at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != W'(MAX))) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported unified memory between instruction fetch
// and the MEM stage. MEM normally wins, but after STARVE_MAX consecutive MEM
// grants with IF waiting, IF is forced through. Accesses that see no ram_ack
// within TIMEOUT wait cycles are aborted with a sticky err flag.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_r;
  logic [SW-1:0] starve_r;
  logic          ram_req_r;
  logic          ram_we_r;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_wdata_r;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] mem_rdata_r;
  logic          if_done_r;
  logic          mem_done_r;
  logic          err_r;

  logic          mem_pend_s;
  logic          if_forced_s;
  logic          waiting_s;
  logic          tmo_clr_s;
  logic          tmo_inc_s;
  logic          tmo_expired_s;

  assign mem_pend_s  = mem_rd | mem_wr;
  assign if_forced_s = if_req && (starve_r == SW'(STARVE_MAX));
  assign waiting_s   = (state_r == ST_IF_WAIT) || (state_r == ST_MEM_WAIT);

  // Timeout counter runs only while an access is outstanding and unanswered.
  always_comb begin
    tmo_clr_s = 1'b1;
    tmo_inc_s = 1'b0;
    if (waiting_s && !ram_ack && !tmo_expired_s) begin
      tmo_clr_s = 1'b0;
      tmo_inc_s = 1'b1;
    end else begin
      tmo_clr_s = 1'b1;
      tmo_inc_s = 1'b0;
    end
  end

  arb_timeout_cnt #(
    .MAX (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (CLK),
    .rst     (RST),
    .clr     (tmo_clr_s),
    .inc     (tmo_inc_s),
    .expired (tmo_expired_s)
  );

  // Grant FSM: latches the winning request, holds the memory handshake and
  // turns ack or timeout into a one-cycle done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      starve_r    <= {SW{1'b0}};
      ram_req_r   <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {AW{1'b0}};
      ram_wdata_r <= {DW{1'b0}};
      if_rdata_r  <= {DW{1'b0}};
      mem_rdata_r <= {DW{1'b0}};
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if_done_r  <= 1'b0;
      mem_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_pend_s && !if_forced_s) begin
            state_r     <= ST_MEM_WAIT;
            ram_req_r   <= 1'b1;
            ram_we_r    <= mem_wr;
            ram_addr_r  <= mem_addr;
            ram_wdata_r <= mem_wdata;
            starve_r    <= if_req ? (starve_r + SW'(1)) : {SW{1'b0}};
          end else if (if_req) begin
            state_r     <= ST_IF_WAIT;
            ram_req_r   <= 1'b1;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= if_addr;
            ram_wdata_r <= {DW{1'b0}};
            starve_r    <= {SW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_IF_WAIT: begin
          if (ram_ack) begin
            if_rdata_r <= ram_rdata;
            if_done_r  <= 1'b1;
            ram_req_r  <= 1'b0;
            ram_we_r   <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (tmo_expired_s) begin
            if_rdata_r <= {DW{TIMEOUT_FILL_BIT}};
            if_done_r  <= 1'b1;
            err_r      <= 1'b1;
            ram_req_r  <= 1'b0;
            ram_we_r   <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_IF_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (ram_ack) begin
            // A write completes with a done pulse but leaves read data alone.
            if (!ram_we_r) begin
              mem_rdata_r <= ram_rdata;
            end else begin
              mem_rdata_r <= mem_rdata_r;
            end
            mem_done_r <= 1'b1;
            ram_req_r  <= 1'b0;
            ram_we_r   <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (tmo_expired_s) begin
            if (!ram_we_r) begin
              mem_rdata_r <= {DW{TIMEOUT_FILL_BIT}};
            end else begin
              mem_rdata_r <= mem_rdata_r;
            end
            mem_done_r <= 1'b1;
            err_r      <= 1'b1;
            ram_req_r  <= 1'b0;
            ram_we_r   <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_MEM_WAIT;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          ram_req_r <= 1'b0;
          ram_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_req   = ram_req_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign if_done   = if_done_r;
  assign mem_rdata = mem_rdata_r;
  assign mem_done  = mem_done_r;
  assign err       = err_r;

  // Stalls follow the live request lines so the pipe releases on the done cycle.
  assign stall_if  = if_req & ~if_done_r;
  assign stall_mem = mem_pend_s & ~mem_done_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single-cycle vectors with
// hand-computed expectations, followed by sequences for starvation, timeout
// and mid-access reset.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RST;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  int n_cmp;
  int n_fail;

  mem_port_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_done;
    logic [31:0] e_if_rdata;
    logic        e_mem_done;
    logic [31:0] e_mem_rdata;
    logic        e_stall_if;
    logic        e_stall_mem;
    logic        e_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    ram_rdata = 32'h0;
    ram_ack   = 1'b0;
  endtask

  vec_t        vecs[12];
  logic [31:0] grants[4];
  int          ngr;
  int          cyc;
  int          cnt;
  int          dones;
  logic        prev_req;
  logic        seen;

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //        if  if_addr       rd    wr    mem_addr      mem_wdata     ram_rdata     ack | req   we    addr          wdata         ifd   if_rdata      md    mem_rdata     sif   smem  err
    vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        32'h11111111, 1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        1'b1, 32'h11111111, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        1'b0, 32'h11111111, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'h12345678, 32'h0,        1'b0, 1'b1, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'h11111111, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'h12345678, 32'h0,        1'b0, 1'b1, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'h11111111, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'h12345678, 32'hBAD0BAD0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h12345678, 1'b0, 32'h11111111, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h200, 32'h12345678, 1'b0, 32'h11111111, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};

    // Power-on reset.
    clear_inputs();
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ram_req",   {31'h0, ram_req},  32'h0);
    chk("rst_ram_addr",  ram_addr,          32'h0);
    chk("rst_if_rdata",  if_rdata,          32'h0);
    chk("rst_mem_rdata", mem_rdata,         32'h0);
    chk("rst_err",       {31'h0, err},      32'h0);

    // Table vectors: apply at a falling edge, check at the next falling edge.
    for (int i = 0; i < 12; i++) begin
      if_req    = vecs[i].if_req;
      if_addr   = vecs[i].if_addr;
      mem_rd    = vecs[i].mem_rd;
      mem_wr    = vecs[i].mem_wr;
      mem_addr  = vecs[i].mem_addr;
      mem_wdata = vecs[i].mem_wdata;
      ram_rdata = vecs[i].ram_rdata;
      ram_ack   = vecs[i].ram_ack;
      @(negedge CLK);
      chk($sformatf("v%0d_ram_req", i),   {31'h0, ram_req},   {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d_ram_we", i),    {31'h0, ram_we},    {31'h0, vecs[i].e_we});
      chk($sformatf("v%0d_ram_addr", i),  ram_addr,           vecs[i].e_addr);
      chk($sformatf("v%0d_ram_wdata", i), ram_wdata,          vecs[i].e_wdata);
      chk($sformatf("v%0d_if_done", i),   {31'h0, if_done},   {31'h0, vecs[i].e_if_done});
      chk($sformatf("v%0d_if_rdata", i),  if_rdata,           vecs[i].e_if_rdata);
      chk($sformatf("v%0d_mem_done", i),  {31'h0, mem_done},  {31'h0, vecs[i].e_mem_done});
      chk($sformatf("v%0d_mem_rdata", i), mem_rdata,          vecs[i].e_mem_rdata);
      chk($sformatf("v%0d_stall_if", i),  {31'h0, stall_if},  {31'h0, vecs[i].e_stall_if});
      chk($sformatf("v%0d_stall_mem", i), {31'h0, stall_mem}, {31'h0, vecs[i].e_stall_mem});
      chk($sformatf("v%0d_err", i),       {31'h0, err},       {31'h0, vecs[i].e_err});
    end
    clear_inputs();

    // Starvation: MEM requests continuously while IF waits; memory acks at once.
    if_req   = 1'b1;
    if_addr  = 32'h40;
    mem_rd   = 1'b1;
    mem_addr = 32'h300;
    ngr      = 0;
    cyc      = 0;
    prev_req = 1'b0;
    while (ngr < 4 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (ram_req && !prev_req) begin
        grants[ngr] = ram_addr;
        ngr++;
      end
      prev_req = ram_req;
      ram_ack  = ram_req;
    end
    chk("starve_grant_count", ngr, 32'd4);
    if (ngr == 4) begin
      chk("starve_grant0", grants[0], 32'h300);
      chk("starve_grant1", grants[1], 32'h300);
      chk("starve_grant2", grants[2], 32'h300);
      chk("starve_grant3", grants[3], 32'h40);
    end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (if_done) begin
        seen = 1'b1;
        break;
      end
      ram_ack = ram_req;
    end
    chk("starve_if_done", {31'h0, seen}, 32'h1);
    clear_inputs();

    // Timeout: a read the memory never answers.
    mem_rd   = 1'b1;
    mem_addr = 32'h500;
    cnt      = 0;
    seen     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (mem_done) begin
        seen = 1'b1;
        break;
      end
      if (ram_req) cnt++;
    end
    chk("tmo_done_seen", {31'h0, seen}, 32'h1);
    chk("tmo_req_cycles", cnt, 32'd16);
    chk("tmo_rdata", mem_rdata, 32'hFFFFFFFF);
    chk("tmo_err", {31'h0, err}, 32'h1);
    chk("tmo_ram_req_low", {31'h0, ram_req}, 32'h0);
    clear_inputs();

    // Access after a timeout proceeds normally and err stays set.
    if_req    = 1'b1;
    if_addr   = 32'h44;
    ram_rdata = 32'hA5A50044;
    seen      = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (if_done) begin
        seen = 1'b1;
        break;
      end
      ram_ack = ram_req;
    end
    chk("post_tmo_done", {31'h0, seen}, 32'h1);
    chk("post_tmo_rdata", if_rdata, 32'hA5A50044);
    chk("post_tmo_err", {31'h0, err}, 32'h1);
    clear_inputs();

    // Reset in the middle of a MEM access.
    mem_rd   = 1'b1;
    mem_addr = 32'h600;
    @(negedge CLK);
    chk("rstmid_granted", {31'h0, ram_req}, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    chk("rstmid_req_drop", {31'h0, ram_req}, 32'h0);
    chk("rstmid_addr",     ram_addr,         32'h0);
    chk("rstmid_err",      {31'h0, err},     32'h0);
    clear_inputs();
    ram_ack = 1'b1;
    @(negedge CLK);
    RST     = 1'b0;
    ram_ack = 1'b0;
    dones   = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (mem_done) dones++;
    end
    chk("rstmid_no_done",  dones,               32'd0);
    chk("rstmid_ram_req",  {31'h0, ram_req},    32'h0);
    chk("rstmid_wdata",    ram_wdata,           32'h0);
    chk("rstmid_if_rdata", if_rdata,            32'h0);
    chk("rstmid_mem_rdata", mem_rdata,          32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
